// File: rtl/ama_riscv_defines.sv
// Shared ama_riscv core constants: register file geometry and reset value.
// No logic; imported by every core module that needs these widths.
// No flow control; constants only.
package ama_riscv_defines;

    localparam int          REG_DATA_WIDTH = 32;
    localparam int          REG_ADDR_WIDTH = 5;
    localparam int          REG_NUM        = 32;
    localparam logic [31:0] RST_VAL        = 32'h0;

endpackage

// File: rtl/ama_riscv_reg_file.sv
// RV32I integer register file: 31 stored regs plus hardwired x0, 2 read ports, 1 write port.
// Reads are combinational (0 cycles); writes land on the next rising clk edge.
// No backpressure: a write is always accepted; no bypass from D to A/B.
module ama_riscv_reg_file
    import ama_riscv_defines::*;
#(
    parameter int DATA_W   = REG_DATA_WIDTH,
    parameter int ADDR_W   = REG_ADDR_WIDTH,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] data_d,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] wr_sel;

    // x0 has no storage; the loop starts at 1 so a write to address 0 selects nothing.
    for (genvar i = 1; i < NUM_REGS; i++) begin : gen_reg
        logic [DATA_W-1:0] q;

        assign wr_sel[i] = we && (addr_d == ADDR_W'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= DATA_W'(RST_VAL);
            end else if (wr_sel[i]) begin
                q <= data_d;
            end
        end

        assign regs[i] = q;
    end

    // Address 0 falls through to the zero default on both ports.
    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (addr_a == ADDR_W'(i)) data_a = regs[i];
            if (addr_b == ADDR_W'(i)) data_b = regs[i];
        end
    end

endmodule

// File: tb/tb_ama_riscv_reg_file.sv
// Directed plus randomized bench for ama_riscv_reg_file against an array model.
module tb_ama_riscv_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_d;
    logic [31:0] data_d;
    logic [31:0] data_a;
    logic [31:0] data_b;

    int checks;
    int errors;

    // Architectural view: model[0] is always zero.
    logic [31:0] model [32];

    ama_riscv_reg_file dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .addr_d (addr_d),
        .data_d (data_d),
        .data_a (data_a),
        .data_b (data_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
        addr_a = a;
        addr_b = b;
        #1;
        check({tag, "_a"}, data_a, model[a]);
        check({tag, "_b"}, data_b, model[b]);
    endtask

    // Drive a write at the falling edge, let the rising edge commit it.
    task automatic write_cycle(input logic w, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we     = w;
        addr_d = a;
        data_d = d;
        @(posedge clk);
        if (w && a != 5'd0) model[a] = d;
        #1;
        we = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_model();
        we     = 1'b0;
        addr_a = '0;
        addr_b = '0;
        addr_d = '0;
        data_d = '0;

        // Reset held for 3 cycles, with a write attempt that must be ignored.
        rst = 1'b0;
        #1;
        check("rst_during_a", data_a, 32'h0);
        we     = 1'b1;
        addr_d = 5'd4;
        data_d = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        we = 1'b0;
        read_check("rst_blocked_wr", 5'd4, 5'd4);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) read_check("rst_sweep", 5'(i), 5'(i));

        // Fill x1..x31 with random values; x5 gets a fixed value.
        for (int i = 1; i < 32; i++) begin
            logic [31:0] v;
            v = (i == 5) ? 32'h1215_3524 : $urandom();
            write_cycle(1'b1, 5'(i), v);
        end
        for (int i = 1; i < 32; i++) read_check("readback", 5'(i), 5'(32 - i));
        for (int i = 1; i < 32; i++) read_check("readback_same", 5'(i), 5'(i));
        addr_a = 5'd5;
        #1;
        check("x5_fixed", data_a, 32'h1215_3524);

        // x0 is not writable.
        write_cycle(1'b1, 5'd0, 32'hDEAD_BEEF);
        read_check("x0", 5'd0, 5'd0);
        check("x0_const", data_a, 32'h0);

        // we=0 leaves the register untouched.
        write_cycle(1'b1, 5'd7, 32'hA5A5_A5A5);
        write_cycle(1'b0, 5'd7, 32'h0);
        addr_a = 5'd7;
        #1;
        check("we0_x7", data_a, 32'hA5A5_A5A5);

        // Same-cycle read and write of x3: old value before the edge, new after.
        write_cycle(1'b1, 5'd3, 32'h55);
        @(negedge clk);
        addr_a = 5'd3;
        addr_b = 5'd9;
        we     = 1'b1;
        addr_d = 5'd3;
        data_d = 32'h1;
        #1;
        check("rw_before_a", data_a, 32'h55);
        check("rw_before_b", data_b, model[9]);
        @(posedge clk);
        model[3] = 32'h1;
        #1;
        we = 1'b0;
        check("rw_after_a", data_a, 32'h1);
        check("rw_after_b", data_b, model[9]);

        // Random mix of writes (including x0 and we=0) and reads.
        for (int n = 0; n < 300; n++) begin
            write_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            read_check("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Async reset in mid-cycle: all reads zero before the next rising edge.
        for (int i = 1; i < 32; i++) write_cycle(1'b1, 5'(i), $urandom() | 32'h1);
        @(negedge clk);
        we     = 1'b1;
        addr_d = 5'd12;
        data_d = 32'h1234_5678;
        #2;
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 16; i++) read_check("async_rst", 5'(i), 5'(i + 16));
        @(posedge clk);
        #1;
        read_check("async_rst_wr_blocked", 5'd12, 5'd12);
        we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        write_cycle(1'b1, 5'd12, 32'hCAFE_F00D);
        read_check("post_rst_wr", 5'd12, 5'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
